// File: rtl/dram_seq_pkg.sv
// Shared types for the DRAM row/column address sequencer: sequencer states,
// address-mux source encoding and a small helper for sizing duration counters.
package dram_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ROW  = 3'd1,
    MUX  = 3'd2,
    CAS  = 3'd3,
    REF  = 3'd4,
    PRE  = 3'd5
  } seq_state_e;

  typedef enum logic [1:0] {
    SRC_ROW = 2'd0,
    SRC_COL = 2'd1,
    SRC_REF = 2'd2
  } mux_src_e;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/addr_mux3_oe.sv
// Combinational 3:1 address mux (row latch, column latch, refresh counter)
// with an active-low tri-state output enable.
module addr_mux3_oe
  import dram_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] i_row,
  input  logic [ADDR_W-1:0] i_col,
  input  logic [ADDR_W-1:0] i_ref,
  input  mux_src_e          i_src,
  input  logic              i_oe_n,
  output wire  [ADDR_W-1:0] o_ma
);

  logic [ADDR_W-1:0] w_mux;

  always_comb begin
    w_mux = i_row;
    case (i_src)
      SRC_ROW: w_mux = i_row;
      SRC_COL: w_mux = i_col;
      SRC_REF: w_mux = i_ref;
      default: w_mux = i_row;
    endcase
  end

  assign o_ma = i_oe_n ? {ADDR_W{1'bz}} : w_mux;

endmodule

// File: rtl/dram_addr_sequencer.sv
// DRAM row/column address sequencer: latches a CPU request, runs RAS/CAS timing,
// and interleaves RAS-only refresh from a wrapping row counter (refresh has priority).
module dram_addr_sequencer
  import dram_seq_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned T_RCD     = 2,
  parameter int unsigned T_CAS     = 2,
  parameter int unsigned T_RAS_REF = 3,
  parameter int unsigned T_RP      = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req,
  input  logic [2*ADDR_W-1:0] addr_in,
  input  logic                refresh_req,
  input  logic                oe_n,
  output wire  [ADDR_W-1:0]   ma,
  output logic                ras_n,
  output logic                cas_n,
  output logic                sel,
  output logic                busy,
  output logic                ack
);

  localparam int unsigned TMAX  = max4(T_RCD, T_CAS, T_RAS_REF, T_RP);
  localparam int unsigned CNT_W = $clog2(TMAX + 1);

  localparam logic [CNT_W-1:0] RCD_LAST = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] CAS_LAST = CNT_W'(T_CAS - 1);
  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(T_RAS_REF - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(T_RP - 1);

  seq_state_e        r_state, w_state_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic              r_pend, w_pend_d;
  logic [ADDR_W-1:0] r_row, r_col, r_ref_cnt;
  mux_src_e          r_src, w_src_d;
  logic              r_ras_n, w_ras_n_d;
  logic              r_cas_n, w_cas_n_d;
  logic              r_sel, w_sel_d;
  logic              r_busy, w_busy_d;
  logic              r_ack, w_ack_d;
  logic              w_latch;
  logic              w_ref_done;

  // Next state, duration counter and pending-refresh flag.
  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt + 1'b1;
    w_pend_d   = r_pend | refresh_req;
    w_latch    = 1'b0;
    w_ref_done = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_d  = '0;
        // Leaving IDLE via REF consumes the pending request; otherwise none is pending.
        w_pend_d = 1'b0;
        if (r_pend || refresh_req) begin
          w_state_d = REF;
        end else if (req) begin
          w_state_d = ROW;
          w_latch   = 1'b1;
        end
      end
      ROW: begin
        if (r_cnt == RCD_LAST) begin
          w_state_d = MUX;
          w_cnt_d   = '0;
        end
      end
      MUX: begin
        w_state_d = CAS;
        w_cnt_d   = '0;
      end
      CAS: begin
        if (r_cnt == CAS_LAST) begin
          w_state_d = PRE;
          w_cnt_d   = '0;
        end
      end
      REF: begin
        if (r_cnt == REF_LAST) begin
          w_state_d  = PRE;
          w_cnt_d    = '0;
          w_ref_done = 1'b1;
        end
      end
      PRE: begin
        if (r_cnt == RP_LAST) begin
          w_state_d = IDLE;
          w_cnt_d   = '0;
        end
      end
      default: begin
        w_state_d = IDLE;
        w_cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_comb begin
    w_ras_n_d = 1'b1;
    w_cas_n_d = 1'b1;
    w_sel_d   = r_sel;
    w_src_d   = r_src;
    w_ack_d   = 1'b0;
    w_busy_d  = (w_state_d != IDLE);
    unique case (w_state_d)
      ROW: begin
        w_ras_n_d = 1'b0;
        w_sel_d   = 1'b0;
        w_src_d   = SRC_ROW;
      end
      MUX: begin
        w_ras_n_d = 1'b0;
        w_sel_d   = 1'b1;
        w_src_d   = SRC_COL;
      end
      CAS: begin
        w_ras_n_d = 1'b0;
        w_cas_n_d = 1'b0;
        w_sel_d   = 1'b1;
        w_src_d   = SRC_COL;
        w_ack_d   = (w_cnt_d == CAS_LAST);
      end
      REF: begin
        w_ras_n_d = 1'b0;
        w_sel_d   = 1'b0;
        w_src_d   = SRC_REF;
      end
      PRE: begin
        // The refreshed row is parked in the row latch so ma holds while the counter advances.
        if (w_ref_done) w_src_d = SRC_ROW;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pend    <= 1'b0;
      r_row     <= '0;
      r_col     <= '0;
      r_ref_cnt <= '0;
      r_src     <= SRC_ROW;
      r_ras_n   <= 1'b1;
      r_cas_n   <= 1'b1;
      r_sel     <= 1'b0;
      r_busy    <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_pend  <= w_pend_d;
      r_src   <= w_src_d;
      r_ras_n <= w_ras_n_d;
      r_cas_n <= w_cas_n_d;
      r_sel   <= w_sel_d;
      r_busy  <= w_busy_d;
      r_ack   <= w_ack_d;
      if (w_latch) begin
        r_row <= addr_in[2*ADDR_W-1:ADDR_W];
        r_col <= addr_in[ADDR_W-1:0];
      end else if (w_ref_done) begin
        r_row <= r_ref_cnt;
      end
      if (w_ref_done) r_ref_cnt <= r_ref_cnt + 1'b1;
    end
  end

  addr_mux3_oe #(
    .ADDR_W (ADDR_W)
  ) u_ma_mux (
    .i_row  (r_row),
    .i_col  (r_col),
    .i_ref  (r_ref_cnt),
    .i_src  (r_src),
    .i_oe_n (oe_n),
    .o_ma   (ma)
  );

  assign ras_n = r_ras_n;
  assign cas_n = r_cas_n;
  assign sel   = r_sel;
  assign busy  = r_busy;
  assign ack   = r_ack;

endmodule
